// File: rtl/spm_serial_mult.sv
// Serial-parallel carry-save multiplier, WIDTH cells, valid/ready operand/result handshake.
// Optional serial product tap on p_bit/p_bit_valid when SPM_SERIAL_OUT_EN is defined.
module spm_serial_mult #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
`ifdef SPM_SERIAL_OUT_EN
    ,
    output logic               p_bit,
    output logic               p_bit_valid
`endif
);

    localparam int CW = $clog2(2*WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(2*WIDTH-1);
    // Signed mode inverts the MSB partial product; the constant that restores
    // the value mod 2^(2*WIDTH) is preloaded as a carry into the MSB cell.
    localparam logic [WIDTH-1:0] C_INIT = {SIGNED, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_sh;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] c_d;
    logic [CW-1:0]    cnt;
    logic             ybit;
    logic             y_fill;

    assign ybit   = y_sh[0];
    assign y_fill = SIGNED ? y_sh[WIDTH-1] : 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : csa
        logic pp;
        logic sin;
        if (SIGNED && i == WIDTH-1) begin : g_pp
            assign pp = ~(x_q[i] & ybit);
        end else begin : g_pp
            assign pp = x_q[i] & ybit;
        end
        if (i == WIDTH-1) begin : g_sin
            assign sin = 1'b0;
        end else begin : g_sin
            assign sin = s_q[i+1];
        end
        assign s_d[i] = pp ^ sin ^ c_q[i];
        assign c_d[i] = (pp & sin) | (pp & c_q[i]) | (sin & c_q[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
            x_q       <= '0;
            y_sh      <= '0;
            s_q       <= '0;
            c_q       <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q      <= x;
                        y_sh     <= y;
                        s_q      <= '0;
                        c_q      <= C_INIT;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    s_q     <= s_d;
                    c_q     <= c_d;
                    y_sh    <= {y_fill, y_sh[WIDTH-1:1]};
                    product <= {s_d[0], product[2*WIDTH-1:1]};
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPM_SERIAL_OUT_EN
    assign p_bit       = (state == RUN) & s_d[0];
    assign p_bit_valid = (state == RUN);
`endif

endmodule

// File: tb/tb_spm_serial_mult.sv
// Bench for spm_serial_mult: unsigned and signed instances driven in lockstep,
// results compared with plain integer multiplication.
module tb_spm_serial_mult;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;

    logic           in_ready_u, out_valid_u, busy_u;
    logic           in_ready_s, out_valid_s, busy_s;
    logic [2*W-1:0] product_u, product_s;
`ifdef SPM_SERIAL_OUT_EN
    logic p_bit_u, p_bit_valid_u, p_bit_s, p_bit_valid_s;
`endif

    int errors = 0;
    int checks = 0;
    logic [2*W-1:0] last_u;

    always #5 clk = ~clk;

    spm_serial_mult #(.WIDTH(W), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .x(x), .y(y), .out_valid(out_valid_u), .out_ready(out_ready),
        .product(product_u), .busy(busy_u)
`ifdef SPM_SERIAL_OUT_EN
        , .p_bit(p_bit_u), .p_bit_valid(p_bit_valid_u)
`endif
    );

    spm_serial_mult #(.WIDTH(W), .SIGNED(1'b1)) s_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .x(x), .y(y), .out_valid(out_valid_s), .out_ready(out_ready),
        .product(product_s), .busy(busy_s)
`ifdef SPM_SERIAL_OUT_EN
        , .p_bit(p_bit_s), .p_bit_valid(p_bit_valid_s)
`endif
    );

    // One operation on both instances; hold>0 stalls the consumer that many cycles.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [2*W-1:0] exp_u;
        logic signed [2*W-1:0] exp_s;
        logic [2*W-1:0] ser;
        int n, nbusy, nser;
        exp_u = a * b;
        exp_s = $signed(a) * $signed(b);
        ser = '0;
        nser = 0;
        checks++;
        if (in_ready_u !== 1'b1 || in_ready_s !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_idle a=%h b=%h got u=%b s=%b want 1", a, b, in_ready_u, in_ready_s);
        end
        out_ready = (hold == 0);
        x = a;
        y = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        nbusy = 0;
        while (!out_valid_u && n < 40) begin
            if (busy_u && busy_s) nbusy++;
`ifdef SPM_SERIAL_OUT_EN
            if (p_bit_valid_u && nser < 2*W) begin
                ser[nser] = p_bit_u;
                nser++;
            end
`endif
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 2*W+1 || out_valid_s !== 1'b1) begin
            errors++;
            $display("FAIL latency a=%h b=%h got %0d (s_valid=%b) want %0d", a, b, n, out_valid_s, 2*W+1);
        end
        checks++;
        if (nbusy != 2*W) begin
            errors++;
            $display("FAIL busy_cycles a=%h b=%h got %0d want %0d", a, b, nbusy, 2*W);
        end
        checks++;
        if (product_u !== exp_u) begin
            errors++;
            $display("FAIL product_unsigned a=%h b=%h got %h want %h", a, b, product_u, exp_u);
        end
        checks++;
        if (product_s !== exp_s) begin
            errors++;
            $display("FAIL product_signed a=%h b=%h got %h want %h", a, b, product_s, exp_s);
        end
`ifdef SPM_SERIAL_OUT_EN
        checks++;
        if (nser != 2*W || ser !== exp_u || p_bit_valid_u !== 1'b0) begin
            errors++;
            $display("FAIL serial_tap a=%h b=%h got %h (%0d bits) want %h", a, b, ser, nser, exp_u);
        end
`endif
        last_u = product_u;
        for (int h = 0; h < hold; h++) begin
            checks++;
            if (out_valid_u !== 1'b1 || in_ready_u !== 1'b0 || product_u !== exp_u) begin
                errors++;
                $display("FAIL hold h=%0d got v=%b r=%b p=%h want v=1 r=0 p=%h", h, out_valid_u, in_ready_u, product_u, exp_u);
            end
            x = ~a;
            y = ~b;
            in_valid = h[0];
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (hold > 0) begin
            checks++;
            if (out_valid_u !== 1'b1 || product_u !== exp_u || product_s !== exp_s) begin
                errors++;
                $display("FAIL hold_end got v=%b p=%h want v=1 p=%h", out_valid_u, product_u, exp_u);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (out_valid_u !== 1'b0 || in_ready_u !== 1'b1 || busy_u !== 1'b0 || in_ready_s !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake got v=%b r=%b busy=%b want v=0 r=1 busy=0", out_valid_u, in_ready_u, busy_u);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready_u !== 1'b1 || out_valid_u !== 1'b0 || busy_u !== 1'b0 || product_u !== '0) begin
            errors++;
            $display("FAIL reset_u got r=%b v=%b busy=%b p=%h want 1 0 0 0", in_ready_u, out_valid_u, busy_u, product_u);
        end
        checks++;
        if (in_ready_s !== 1'b1 || out_valid_s !== 1'b0 || busy_s !== 1'b0 || product_s !== '0) begin
            errors++;
            $display("FAIL reset_s got r=%b v=%b busy=%b p=%h want 1 0 0 0", in_ready_s, out_valid_s, busy_s, product_s);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned_max();
        do_op(8'hFF, 8'hFF, 0);
        checks++;
        if (last_u !== 16'hFE01) begin
            errors++;
            $display("FAIL ff_times_ff got %h want fe01", last_u);
        end
    endtask

    task automatic test_signed();
        do_op(8'hFD, 8'h05, 0);
        do_op(8'h80, 8'h80, 0);
        do_op(8'h7F, 8'h80, 0);
    endtask

    task automatic test_backpressure();
        do_op(8'hFF, 8'hFF, 5);
        do_op(8'h12, 8'h34, 0);
    endtask

    task automatic test_reset_mid_run();
        x = 8'hAB;
        y = 8'hCD;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (out_valid_u !== 1'b0 || busy_u !== 1'b0 || in_ready_u !== 1'b1 || product_u !== '0) begin
            errors++;
            $display("FAIL reset_mid_run got v=%b busy=%b r=%b p=%h want 0 0 1 0", out_valid_u, busy_u, in_ready_u, product_u);
        end
        checks++;
        if (out_valid_s !== 1'b0 || busy_s !== 1'b0 || in_ready_s !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_run_s got v=%b busy=%b r=%b want 0 0 1", out_valid_s, busy_s, in_ready_s);
        end
        do_op(8'h03, 8'h04, 0);
    endtask

    task automatic test_edges();
        do_op(8'h00, 8'h80, 0);
        do_op(8'h01, 8'hFF, 0);
        do_op(8'h80, 8'h01, 0);
        do_op(8'h7F, 8'h7F, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            do_op(W'($urandom), W'($urandom), (i % 7 == 3) ? 2 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_backpressure();
        test_reset_mid_run();
        test_edges();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
